sddt_pattern_driver: RTL
========================

SDDT_PATTERN_DRIVER -- requirements
Module: sddt_pattern_driver

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 128, command word width.
REQ-002 SHALL have parameter WDATA_WIDTH, default 512, write/read beat width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, burst counter width.
REQ-004 SHALL have parameters ACT_WAIT=16, CAS_WAIT=4, PRE_WAIT=16 (cycles), TIMEOUT=4096 (cycles).
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset (one clock; reset asynchronous, active-high).
REQ-006 SHALL have ports: start in 1 launch pulse; bg in 2; bank in 2; row in 17; num_bursts in CNT_WIDTH; seed in 32.
REQ-007 SHALL have ports: busy out 1; done out 1 sticky; timeout out 1 sticky; error_count out CNT_WIDTH; first_err_idx out CNT_WIDTH.
REQ-008 SHALL have ports: M_AXIS_CMD_tdata out INSTR_WIDTH, M_AXIS_CMD_tvalid out 1, M_AXIS_CMD_tready in 1.
REQ-009 SHALL have ports: M_AXIS_WDATA_tdata out WDATA_WIDTH, M_AXIS_WDATA_tvalid out 1, M_AXIS_WDATA_tready in 1.
REQ-010 SHALL have ports: S_AXIS_RDATA_tdata in WDATA_WIDTH, S_AXIS_RDATA_tvalid in 1, S_AXIS_RDATA_tready out 1, S_AXIS_RDATA_tlast in 1 (ignored).

Function
REQ-011 Command word SHALL be: [127:124] opcode (ACT=1, WR=2, RD=3, PRE=4), [123:122] bg, [121:120] bank, [119:103] row, [102:93] col, [92:32] zero, [31:0] wait.
REQ-012 Burst i SHALL use col = i*8 (mod 1024) and pattern P(i) = 32-bit (seed+i) replicated 16 times.
REQ-013 FSM states SHALL be IDLE, ACT, WR, RD, PRE, DRAIN, DONE.
REQ-014 IDLE: start=1 latches bg/bank/row/num_bursts/seed, clears done/timeout/error_count, sets first_err_idx all-ones, goes to ACT; num_bursts=0 goes directly to DONE with no commands.
REQ-015 start while not IDLE/DONE SHALL be ignored; start in DONE behaves as in IDLE.
REQ-016 ACT: emits one ACT word, wait=ACT_WAIT; on cmd handshake goes to WR.
REQ-017 WR: per burst, WR word (wait=CAS_WAIT) and P(i) presented concurrently; each tvalid held until its own handshake, per-stream accepted flag kept; burst advances when both accepted; after num_bursts bursts goes to RD.
REQ-018 WDATA tvalid SHALL never be asserted outside WR; WR word and its data SHALL belong to the same burst index.
REQ-019 RD: emits num_bursts RD words (wait=CAS_WAIT), cols as REQ-012, then PRE.
REQ-020 PRE: emits PRE word, wait=PRE_WAIT, then DRAIN.
REQ-021 tvalid SHALL stay asserted with stable tdata until tready (AXI-Stream rules); no combinational tready->tvalid path.
REQ-022 S_AXIS_RDATA_tready SHALL be 1 in all states after reset; beats arriving in IDLE/DONE are discarded uncounted.
REQ-023 Receive counter k SHALL run independently of the issue FSM (beats may arrive during RD/PRE); beat k compared against P(k); mismatch increments error_count (saturating at all-ones) and, if first, records k in first_err_idx.
REQ-024 Beats with k >= num_bursts SHALL count as errors; first_err_idx records as REQ-023.
REQ-025 DRAIN: goes to DONE when k reaches num_bursts; idle-beat counter resets on each beat, on reaching TIMEOUT sets timeout and goes to DONE.
REQ-026 busy=1 in all states except IDLE and DONE; done=1 in DONE.
REQ-027 Command issue latency: first ACT tvalid SHALL assert the cycle after start is sampled.

Reset
REQ-028 rst SHALL asynchronously force: IDLE, all tvalid 0, busy 0, done 0, timeout 0, error_count 0, first_err_idx all-ones, counters 0, tdata 0.
REQ-029 rst mid-operation SHALL abandon the sequence immediately; no partial command completion is required.

Structure
REQ-030 Opcode constants, command field offsets and the pattern function SHALL live in shared package sddt_pkg, shared with the instruction decoder.
REQ-031 Read comparison (counter, compare, error accumulation) SHALL be sub-module sddt_rdata_checker.

Verification
REQ-032 num_bursts=4, seed=0x100, tready always 1, looped-back correct data -> ACT, 4 WR (cols 0,8,16,24, data 0x100..0x103), 4 RD, PRE; done=1, error_count=0, first_err_idx=0xFFFF.
REQ-033 Same, beat 2 corrupted -> error_count=1, first_err_idx=2.
REQ-034 WDATA tready low 5 cycles while CMD tready high -> WR word accepted once, data held stable, burst index advances only after both handshakes.
REQ-035 num_bursts=3, only 2 read beats returned -> timeout=1, done=1 after TIMEOUT idle cycles.
REQ-036 rst asserted during WR burst 1 -> all tvalid 0 immediately, state IDLE; subsequent start runs clean.
REQ-037 num_bursts=0 -> no command handshakes, done=1 in two cycles, error_count=0.

Source files
------------

// File: rtl/sddt_pkg.sv
// Shared definitions for the SDDT command path: opcodes, command field layout, FSM states and
// the write/read test pattern.
package sddt_pkg;

  localparam int unsigned CmdW = 128;
  localparam int unsigned PatW = 512;

  localparam logic [3:0] OpAct = 4'd1;
  localparam logic [3:0] OpWr  = 4'd2;
  localparam logic [3:0] OpRd  = 4'd3;
  localparam logic [3:0] OpPre = 4'd4;

  localparam int unsigned OpLsb   = 124;
  localparam int unsigned BgLsb   = 122;
  localparam int unsigned BankLsb = 120;
  localparam int unsigned RowLsb  = 103;
  localparam int unsigned ColLsb  = 93;
  localparam int unsigned WaitLsb = 0;

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StWr,
    StRd,
    StPre,
    StDrain,
    StDone
  } state_e;

  // Assemble one command word; bits [92:32] stay zero.
  function automatic logic [CmdW-1:0] make_cmd(input logic [3:0]  op,
                                               input logic [1:0]  bg,
                                               input logic [1:0]  bank,
                                               input logic [16:0] row,
                                               input logic [9:0]  col,
                                               input logic [31:0] wait_cyc);
    logic [CmdW-1:0] w;
    w = '0;
    w[OpLsb +: 4]    = op;
    w[BgLsb +: 2]    = bg;
    w[BankLsb +: 2]  = bank;
    w[RowLsb +: 17]  = row;
    w[ColLsb +: 10]  = col;
    w[WaitLsb +: 32] = wait_cyc;
    return w;
  endfunction

  // Burst i targets column i*8, wrapping at 1024.
  function automatic logic [9:0] burst_col(input logic [6:0] idx_lo);
    return {idx_lo, 3'b000};
  endfunction

  // Pattern for burst i: (seed + i) replicated across the beat.
  function automatic logic [PatW-1:0] make_pattern(input logic [31:0] seed,
                                                   input logic [31:0] idx);
    logic [31:0] word;
    word = seed + idx;
    return {16{word}};
  endfunction

endpackage

// File: rtl/sddt_rdata_checker.sv
// Read-data checker: counts returned beats independently of command issue, compares each beat
// against the expected pattern and accumulates errors.
module sddt_rdata_checker
  import sddt_pkg::*;
#(
  parameter int unsigned WDATA_WIDTH = 512,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   active,
  input  logic [CNT_WIDTH-1:0]   num_bursts,
  input  logic [31:0]            seed,
  input  logic [WDATA_WIDTH-1:0] rdata,
  input  logic                   rvalid,
  output logic                   rready,
  output logic                   beat,
  output logic [CNT_WIDTH-1:0]   rx_count,
  output logic [CNT_WIDTH-1:0]   error_count,
  output logic [CNT_WIDTH-1:0]   first_err_idx
);

  logic                 rready_q;
  logic [CNT_WIDTH-1:0] k_q, k_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic [CNT_WIDTH-1:0] first_q, first_d;
  logic                 mismatch;

  // Beats outside an active run are accepted but dropped.
  assign beat = rvalid & rready_q & active;

  // Next-state: clear on launch, otherwise score each accepted beat.
  always_comb begin
    k_d      = k_q;
    err_d    = err_q;
    first_d  = first_q;
    mismatch = (k_q >= num_bursts) ||
               (rdata != WDATA_WIDTH'(make_pattern(seed, 32'(k_q))));
    if (clear) begin
      k_d     = '0;
      err_d   = '0;
      first_d = '1;
    end else if (beat) begin
      if (mismatch) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        if (err_q == '0) first_d = k_q;
      end
      // Saturate so an overrun can never wrap back into the valid range.
      if (k_q != '1) k_d = k_q + 1'b1;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rready_q <= 1'b0;
      k_q      <= '0;
      err_q    <= '0;
      first_q  <= '1;
    end else begin
      rready_q <= 1'b1;
      k_q      <= k_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign rready        = rready_q;
  assign rx_count      = k_q;
  assign error_count   = err_q;
  assign first_err_idx = first_q;

endmodule

// File: rtl/sddt_pattern_driver.sv
// Pattern driver: issues ACT, N write bursts, N reads and PRE on AXI-Stream, then waits for the
// read data to come back and reports errors/timeout.
module sddt_pattern_driver
  import sddt_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 128,
  parameter int unsigned WDATA_WIDTH = 512,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned ACT_WAIT    = 16,
  parameter int unsigned CAS_WAIT    = 4,
  parameter int unsigned PRE_WAIT    = 16,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             bg,
  input  logic [1:0]             bank,
  input  logic [16:0]            row,
  input  logic [CNT_WIDTH-1:0]   num_bursts,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CNT_WIDTH-1:0]   error_count,
  output logic [CNT_WIDTH-1:0]   first_err_idx,
  output logic [INSTR_WIDTH-1:0] M_AXIS_CMD_tdata,
  output logic                   M_AXIS_CMD_tvalid,
  input  logic                   M_AXIS_CMD_tready,
  output logic [WDATA_WIDTH-1:0] M_AXIS_WDATA_tdata,
  output logic                   M_AXIS_WDATA_tvalid,
  input  logic                   M_AXIS_WDATA_tready,
  input  logic [WDATA_WIDTH-1:0] S_AXIS_RDATA_tdata,
  input  logic                   S_AXIS_RDATA_tvalid,
  output logic                   S_AXIS_RDATA_tready,
  input  logic                   S_AXIS_RDATA_tlast
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic [1:0]             bg_q, bg_d, bank_q, bank_d;
  logic [16:0]            row_q, row_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d, burst_q, burst_d, burst_inc;
  logic [31:0]            seed_q, seed_d;
  logic                   cmd_valid_q, cmd_valid_d, wd_valid_q, wd_valid_d;
  logic [INSTR_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [WDATA_WIDTH-1:0] wd_data_q, wd_data_d;
  logic                   cmd_acc_q, cmd_acc_d, wd_acc_q, wd_acc_d;
  logic                   timeout_q, timeout_d;
  logic [IdleW-1:0]       idle_q, idle_d;
  logic                   cmd_hs, wd_hs, cmd_acc_n, wd_acc_n, launch;
  logic                   beat;
  logic [CNT_WIDTH-1:0]   rx_count;
  logic                   unused_tlast;

  assign unused_tlast = S_AXIS_RDATA_tlast;
  assign cmd_hs    = cmd_valid_q & M_AXIS_CMD_tready;
  assign wd_hs     = wd_valid_q & M_AXIS_WDATA_tready;
  assign cmd_acc_n = cmd_acc_q | cmd_hs;
  assign wd_acc_n  = wd_acc_q | wd_hs;
  assign burst_inc = burst_q + 1'b1;
  assign launch    = start & ((state_q == StIdle) || (state_q == StDone));

  // Issue FSM next-state; tvalid/tdata are registered so tready never feeds tvalid.
  always_comb begin
    state_d     = state_q;
    bg_d        = bg_q;
    bank_d      = bank_q;
    row_d       = row_q;
    num_d       = num_q;
    seed_d      = seed_q;
    burst_d     = burst_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    wd_valid_d  = wd_valid_q;
    wd_data_d   = wd_data_q;
    cmd_acc_d   = cmd_acc_q;
    wd_acc_d    = wd_acc_q;
    timeout_d   = timeout_q;
    idle_d      = idle_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (launch) begin
          bg_d      = bg;
          bank_d    = bank;
          row_d     = row;
          num_d     = num_bursts;
          seed_d    = seed;
          burst_d   = '0;
          timeout_d = 1'b0;
          if (num_bursts == '0) begin
            state_d = StDone;
          end else begin
            state_d     = StAct;
            cmd_valid_d = 1'b1;
            cmd_data_d  = INSTR_WIDTH'(make_cmd(OpAct, bg, bank, row, 10'd0, 32'(ACT_WAIT)));
          end
        end
      end
      StAct: begin
        if (cmd_hs) begin
          state_d     = StWr;
          cmd_valid_d = 1'b1;
          cmd_data_d  = INSTR_WIDTH'(make_cmd(OpWr, bg_q, bank_q, row_q, 10'd0, 32'(CAS_WAIT)));
          wd_valid_d  = 1'b1;
          wd_data_d   = WDATA_WIDTH'(make_pattern(seed_q, 32'd0));
          cmd_acc_d   = 1'b0;
          wd_acc_d    = 1'b0;
        end
      end
      StWr: begin
        cmd_acc_d = cmd_acc_n;
        wd_acc_d  = wd_acc_n;
        if (cmd_hs) cmd_valid_d = 1'b0;
        if (wd_hs) wd_valid_d = 1'b0;
        // Both halves of the burst accepted: move on together so WR word and data stay paired.
        if (cmd_acc_n && wd_acc_n) begin
          cmd_acc_d   = 1'b0;
          wd_acc_d    = 1'b0;
          cmd_valid_d = 1'b1;
          if (burst_inc == num_q) begin
            state_d    = StRd;
            burst_d    = '0;
            cmd_data_d = INSTR_WIDTH'(make_cmd(OpRd, bg_q, bank_q, row_q, 10'd0, 32'(CAS_WAIT)));
          end else begin
            burst_d    = burst_inc;
            cmd_data_d = INSTR_WIDTH'(make_cmd(OpWr, bg_q, bank_q, row_q,
                                               burst_col(burst_inc[6:0]), 32'(CAS_WAIT)));
            wd_valid_d = 1'b1;
            wd_data_d  = WDATA_WIDTH'(make_pattern(seed_q, 32'(burst_inc)));
          end
        end
      end
      StRd: begin
        if (cmd_hs) begin
          if (burst_inc == num_q) begin
            state_d    = StPre;
            burst_d    = '0;
            cmd_data_d = INSTR_WIDTH'(make_cmd(OpPre, bg_q, bank_q, row_q, 10'd0, 32'(PRE_WAIT)));
          end else begin
            burst_d    = burst_inc;
            cmd_data_d = INSTR_WIDTH'(make_cmd(OpRd, bg_q, bank_q, row_q,
                                               burst_col(burst_inc[6:0]), 32'(CAS_WAIT)));
          end
        end
      end
      StPre: begin
        if (cmd_hs) begin
          state_d     = StDrain;
          cmd_valid_d = 1'b0;
          idle_d      = '0;
        end
      end
      StDrain: begin
        if (rx_count >= num_q) begin
          state_d = StDone;
        end else if (beat) begin
          idle_d = '0;
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue FSM and stream output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bg_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      num_q       <= '0;
      seed_q      <= '0;
      burst_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      wd_valid_q  <= 1'b0;
      wd_data_q   <= '0;
      cmd_acc_q   <= 1'b0;
      wd_acc_q    <= 1'b0;
      timeout_q   <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      bg_q        <= bg_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      num_q       <= num_d;
      seed_q      <= seed_d;
      burst_q     <= burst_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      wd_valid_q  <= wd_valid_d;
      wd_data_q   <= wd_data_d;
      cmd_acc_q   <= cmd_acc_d;
      wd_acc_q    <= wd_acc_d;
      timeout_q   <= timeout_d;
      idle_q      <= idle_d;
    end
  end

  sddt_rdata_checker #(
    .WDATA_WIDTH (WDATA_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_checker (
    .clk           (clk),
    .rst           (rst),
    .clear         (launch),
    .active        (busy),
    .num_bursts    (num_q),
    .seed          (seed_q),
    .rdata         (S_AXIS_RDATA_tdata),
    .rvalid        (S_AXIS_RDATA_tvalid),
    .rready        (S_AXIS_RDATA_tready),
    .beat          (beat),
    .rx_count      (rx_count),
    .error_count   (error_count),
    .first_err_idx (first_err_idx)
  );

  assign busy                = (state_q != StIdle) && (state_q != StDone);
  assign done                = (state_q == StDone);
  assign timeout             = timeout_q;
  assign M_AXIS_CMD_tvalid   = cmd_valid_q;
  assign M_AXIS_CMD_tdata    = cmd_data_q;
  assign M_AXIS_WDATA_tvalid = wd_valid_q;
  assign M_AXIS_WDATA_tdata  = wd_data_q;

endmodule
